// File: rtl/vga_scan_gen.sv
// VGA scan-timing source: pixel/line counters, active-area x/y,
// pipelined sync outputs and a per-frame tick.
module vga_scan_gen #(
   parameter int   CLK_DIV    = 4,
   parameter int   H_ACTIVE   = 640,
   parameter int   H_FP       = 16,
   parameter int   H_SYNC     = 96,
   parameter int   H_BP       = 48,
   parameter int   V_ACTIVE   = 480,
   parameter int   V_FP       = 10,
   parameter int   V_SYNC     = 2,
   parameter int   V_BP       = 33,
   parameter logic SYNC_POL   = 1'b0,
   parameter int   PIPE_DELAY = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       toDisplay,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0]     div_cnt;
   logic [9:0]        h_cnt;
   logic [9:0]        v_cnt;
   logic              pix_en;
   logic              td_next;
   logic              hs_raw;
   logic              vs_raw;
   logic              last_pix;
   logic [PIPE_DELAY:0] hs_q;
   logic [PIPE_DELAY:0] vs_q;

   always_comb begin
      pix_en   = (div_cnt == DIV_MAX);
      td_next  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs_raw   = (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
      vs_raw   = (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
      last_pix = (h_cnt == H_LAST) && (v_cnt == V_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         div_cnt <= pix_en ? '0 : div_cnt + DW'(1);
         if (pix_en) begin
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x          <= '0;
         y          <= '0;
         toDisplay  <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         x          <= td_next ? h_cnt : '0;
         y          <= td_next ? v_cnt : '0;
         toDisplay  <= td_next;
         frame_tick <= pix_en && last_pix;
      end
   end

   // Stage 0 is the registered raw sync; the rest match renderer latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         hs_q <= {(PIPE_DELAY + 1){~SYNC_POL}};
         vs_q <= {(PIPE_DELAY + 1){~SYNC_POL}};
      end else begin
         hs_q[0] <= hs_raw;
         vs_q[0] <= vs_raw;
         for (int i = 1; i <= PIPE_DELAY; i++) begin
            hs_q[i] <= hs_q[i-1];
            vs_q[i] <= vs_q[i-1];
         end
      end
   end

   assign hsync = hs_q[PIPE_DELAY];
   assign vsync = vs_q[PIPE_DELAY];

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: three parameter sets checked every clk
// against an elapsed-clock arithmetic model, with random resets.
module tb_vga_scan_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b, rst_c;
   logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
   logic       td_a, hs_a, vs_a, ft_a;
   logic       td_b, hs_b, vs_b, ft_b;
   logic       td_c, hs_c, vs_c, ft_c;

   int n_chk  = 0;
   int n_fail = 0;

   vga_scan_gen u_a (
      .clk(clk), .rst(rst_a), .x(x_a), .y(y_a), .toDisplay(td_a),
      .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a)
   );

   vga_scan_gen #(
      .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b0), .PIPE_DELAY(0)
   ) u_b (
      .clk(clk), .rst(rst_b), .x(x_b), .y(y_b), .toDisplay(td_b),
      .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b)
   );

   vga_scan_gen #(
      .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(1'b1), .PIPE_DELAY(3)
   ) u_c (
      .clk(clk), .rst(rst_c), .x(x_c), .y(y_c), .toDisplay(td_c),
      .hsync(hs_c), .vsync(vs_c), .frame_tick(ft_c)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int in_win(input int c, input int a, input int fp, input int sw);
      return (c >= a + fp && c < a + fp + sw) ? 1 : 0;
   endfunction

   // n = clk edges since reset released (0 = edge taken in reset).
   task automatic verify(
      input string tag,
      input int cd, input int ha, input int hf, input int hw, input int hb,
      input int va, input int vf, input int vw, input int vb,
      input int pol, input int pd, input int n,
      input int ox, input int oy, input int otd,
      input int ohs, input int ovs, input int oft
   );
      int ht, vt, p, h, v, m;
      int ex, ey, etd, ehs, evs, eft;
      ht = ha + hf + hw + hb;
      vt = va + vf + vw + vb;
      ex = 0; ey = 0; etd = 0; eft = 0;
      ehs = 1 - pol; evs = 1 - pol;
      if (n > 0) begin
         p   = (n - 1) / cd;
         h   = p % ht;
         v   = (p / ht) % vt;
         etd = (h < ha && v < va) ? 1 : 0;
         ex  = etd ? h : 0;
         ey  = etd ? v : 0;
         m   = n - 1 - pd;
         if (m >= 0) begin
            p   = m / cd;
            h   = p % ht;
            v   = (p / ht) % vt;
            ehs = in_win(h, ha, hf, hw) ? pol : 1 - pol;
            evs = in_win(v, va, vf, vw) ? pol : 1 - pol;
         end
         eft = (n % (cd * ht * vt) == 0) ? 1 : 0;
      end
      chk({tag, ".x"}, ox, ex);
      chk({tag, ".y"}, oy, ey);
      chk({tag, ".toDisplay"}, otd, etd);
      chk({tag, ".hsync"}, ohs, ehs);
      chk({tag, ".vsync"}, ovs, evs);
      chk({tag, ".frame_tick"}, oft, eft);
   endtask

   int na, nb, nc;
   int ra_left, rb_left, rc_left;
   bit a_mid_done;
   int a_hs_low, c_vs_hi;
   int b_ft_cnt, c_ft_cnt;
   bit b_ft_ok, c_ft_ok;

   initial begin
      na = 0; nb = 0; nc = 0;
      ra_left = 3; rb_left = 3; rc_left = 3;
      a_mid_done = 0;
      a_hs_low = 0; c_vs_hi = 0;
      b_ft_cnt = 0; c_ft_cnt = 0;
      b_ft_ok = 0; c_ft_ok = 0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         // line 2, pixel 100 of the default timing
         if (!a_mid_done && ra_left == 0 && na == 6800) begin
            ra_left = 3;
            a_mid_done = 1;
         end
         if (rb_left == 0 && $urandom_range(0, 999) == 0)
            rb_left = $urandom_range(1, 4);
         if (rc_left == 0 && $urandom_range(0, 999) == 0)
            rc_left = $urandom_range(1, 4);
         rst_a = (ra_left > 0);
         rst_b = (rb_left > 0);
         rst_c = (rc_left > 0);
         if (ra_left > 0) ra_left--;
         if (rb_left > 0) rb_left--;
         if (rc_left > 0) rc_left--;

         @(posedge clk);
         #1;
         na = rst_a ? 0 : na + 1;
         nb = rst_b ? 0 : nb + 1;
         nc = rst_c ? 0 : nc + 1;

         verify("a", 4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 2, na,
                int'(x_a), int'(y_a), int'(td_a),
                int'(hs_a), int'(vs_a), int'(ft_a));
         verify("b", 1, 4, 1, 1, 1, 2, 1, 1, 1, 0, 0, nb,
                int'(x_b), int'(y_b), int'(td_b),
                int'(hs_b), int'(vs_b), int'(ft_b));
         verify("c", 3, 8, 2, 3, 2, 5, 2, 2, 3, 1, 3, nc,
                int'(x_c), int'(y_c), int'(td_c),
                int'(hs_c), int'(vs_c), int'(ft_c));

         // hsync pulse width on the default timing
         if (rst_a) a_hs_low = 0;
         else if (hs_a == 1'b0) a_hs_low++;
         else begin
            if (a_hs_low > 0) chk("a.hsync_width", a_hs_low, 384);
            a_hs_low = 0;
         end

         // active-high vsync width: 2 lines of 15 px at 3 clk/px
         if (rst_c) c_vs_hi = 0;
         else if (vs_c == 1'b1) c_vs_hi++;
         else begin
            if (c_vs_hi > 0) chk("c.vsync_width", c_vs_hi, 90);
            c_vs_hi = 0;
         end

         if (rst_b) b_ft_ok = 0;
         else begin
            b_ft_cnt++;
            if (ft_b) begin
               if (b_ft_ok) chk("b.frame_period", b_ft_cnt, 35);
               b_ft_ok = 1;
               b_ft_cnt = 0;
            end
         end

         if (rst_c) c_ft_ok = 0;
         else begin
            c_ft_cnt++;
            if (ft_c) begin
               if (c_ft_ok) chk("c.frame_period", c_ft_cnt, 540);
               c_ft_ok = 1;
               c_ft_cnt = 0;
            end
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
